// File: rtl/painterengine_gpu_dma_burst_writer.sv
// painterengine_gpu_dma_burst_writer
//   Streams beats from one of PARAM_CHANNELS source channels to memory as a
//   sequence of AXI4 INCR write bursts. Bursts are sized so they never exceed
//   PARAM_MAX_BURST beats and never cross a 4 KB boundary.
// Ports:
//   i_wire_clock / i_wire_reset    clock, asynchronous active-high reset
//   i_wire_start                   start pulse (honoured in IDLE/DONE/ERROR)
//   i_wire_router                  one-hot channel select
//   i_wire_address/_length         per-channel byte address / length in beats
//   i_wire_data/_data_valid        per-channel beat and its valid flag
//   o_wire_data_next               per-channel beat-consumed strobe
//   o_wire_busy/_done/_error/_error_type   status
//   aw*/w*/b*                      AXI4 write master channels
// Error types: 1 bad router, 2 misaligned address, 3 zero length,
//   4 AW timeout, 5 bad BRESP, 6 W timeout, 7 B timeout.
module painterengine_gpu_dma_burst_writer #(
  parameter int PARAM_CHANNELS   = 4,
  parameter int PARAM_DATA_WIDTH = 32,
  parameter int PARAM_MAX_BURST  = 256,
  parameter int PARAM_TIMEOUT    = 256
) (
  input  logic                                     i_wire_clock,
  input  logic                                     i_wire_reset,
  input  logic                                     i_wire_start,
  input  logic [PARAM_CHANNELS-1:0]                i_wire_router,
  input  logic [32*PARAM_CHANNELS-1:0]             i_wire_address,
  input  logic [32*PARAM_CHANNELS-1:0]             i_wire_length,
  input  logic [PARAM_DATA_WIDTH*PARAM_CHANNELS-1:0] i_wire_data,
  input  logic [PARAM_CHANNELS-1:0]                i_wire_data_valid,
  output logic [PARAM_CHANNELS-1:0]                o_wire_data_next,
  output logic                                     o_wire_busy,
  output logic                                     o_wire_done,
  output logic                                     o_wire_error,
  output logic [2:0]                               o_wire_error_type,
  output logic                                     awid,
  output logic [31:0]                              awaddr,
  output logic [7:0]                               awlen,
  output logic [2:0]                               awsize,
  output logic [1:0]                               awburst,
  output logic                                     awlock,
  output logic [3:0]                               awcache,
  output logic [2:0]                               awprot,
  output logic [3:0]                               awqos,
  output logic                                     awvalid,
  input  logic                                     awready,
  output logic [PARAM_DATA_WIDTH-1:0]              wdata,
  output logic [PARAM_DATA_WIDTH/8-1:0]            wstrb,
  output logic                                     wlast,
  output logic                                     wvalid,
  input  logic                                     wready,
  input  logic                                     bid,
  input  logic [1:0]                               bresp,
  input  logic                                     bvalid,
  output logic                                     bready
);

  localparam int SIZE_LOG = $clog2(PARAM_DATA_WIDTH / 8);
  localparam int SEL_W    = (PARAM_CHANNELS > 1) ? $clog2(PARAM_CHANNELS) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, CALC, ADDR, DATA, RESP, DONE, ERROR} state_t;

  state_t                    state_reg, state_next;
  logic [PARAM_CHANNELS-1:0] router_reg, router_next;
  logic [31:0]               address_reg, address_next;
  logic [31:0]               length_reg, length_next;
  logic [31:0]               offset_reg, offset_next;
  logic [8:0]                burst_reg, burst_next;
  logic [8:0]                beat_reg, beat_next;
  logic [31:0]               stall_reg, stall_next;
  logic [2:0]                error_type_reg, error_type_next;
  logic [31:0]               awaddr_reg, awaddr_next;
  logic [7:0]                awlen_reg, awlen_next;

  logic [SEL_W-1:0]          start_sel, sel;
  logic                      router_onehot, w_hs, timed_out;
  logic [31:0]               remaining, cur_addr, to_4k, burst32;

  // BID is always 0 (single ID); BRESP[0] only separates OKAY from EXOKAY.
  logic unused_ok;
  assign unused_ok = &{1'b0, bid, bresp[0]};

  // Index of the set router bit, for the incoming request and the latched one.
  always_comb begin
    start_sel = '0;
    sel       = '0;
    for (int i = 0; i < PARAM_CHANNELS; i++) begin
      if (i_wire_router[i]) start_sel = SEL_W'(i);
      if (router_reg[i])    sel       = SEL_W'(i);
    end
  end

  assign router_onehot = (router_reg != '0) && ((router_reg & (router_reg - 1'b1)) == '0);

  // Constant AXI attributes
  assign awid    = 1'b0;
  assign awsize  = 3'(SIZE_LOG);
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'b0010;
  assign awprot  = 3'b000;
  assign awqos   = 4'b0000;
  assign wstrb   = '1;

  assign awaddr  = awaddr_reg;
  assign awlen   = awlen_reg;
  assign awvalid = (state_reg == ADDR);
  assign bready  = (state_reg == RESP);
  assign wdata   = i_wire_data[sel*PARAM_DATA_WIDTH +: PARAM_DATA_WIDTH];
  assign wvalid  = (state_reg == DATA) && i_wire_data_valid[sel];
  assign wlast   = (state_reg == DATA) && (beat_reg == burst_reg - 9'd1);
  assign w_hs    = wvalid && wready;
  // router_reg is one-hot whenever DATA is reachable, so it doubles as the strobe mask.
  assign o_wire_data_next = w_hs ? router_reg : '0;

  assign o_wire_busy       = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
  assign o_wire_done       = (state_reg == DONE);
  assign o_wire_error      = (state_reg == ERROR);
  assign o_wire_error_type = error_type_reg;

  assign timed_out = (stall_reg >= 32'(PARAM_TIMEOUT - 1));

  // Burst sizing: smallest of the configured maximum, what is left, and the
  // beats that fit before the next 4 KB page.
  always_comb begin
    remaining = length_reg - offset_reg;
    cur_addr  = address_reg + (offset_reg << SIZE_LOG);
    to_4k     = (32'h1000 - {20'd0, cur_addr[11:0]}) >> SIZE_LOG;
    burst32   = 32'(PARAM_MAX_BURST);
    if (remaining < burst32) burst32 = remaining;
    if (to_4k < burst32)     burst32 = to_4k;
  end

  always_comb begin
    state_next      = state_reg;
    router_next     = router_reg;
    address_next    = address_reg;
    length_next     = length_reg;
    offset_next     = offset_reg;
    burst_next      = burst_reg;
    beat_next       = beat_reg;
    stall_next      = '0;
    error_type_next = error_type_reg;
    awaddr_next     = awaddr_reg;
    awlen_next      = awlen_reg;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (i_wire_start) begin
          router_next     = i_wire_router;
          address_next    = i_wire_address[start_sel*32 +: 32];
          length_next     = i_wire_length[start_sel*32 +: 32];
          offset_next     = '0;
          error_type_next = 3'd0;
          state_next      = CHECK;
        end
      end
      CHECK: begin
        if (!router_onehot) begin
          error_type_next = 3'd1;
          state_next      = ERROR;
        end else if (address_reg[SIZE_LOG-1:0] != '0) begin
          error_type_next = 3'd2;
          state_next      = ERROR;
        end else if (length_reg == '0) begin
          error_type_next = 3'd3;
          state_next      = ERROR;
        end else begin
          state_next = CALC;
        end
      end
      CALC: begin
        burst_next  = 9'(burst32);
        awaddr_next = cur_addr;
        awlen_next  = 8'(burst32 - 32'd1);
        state_next  = ADDR;
      end
      ADDR: begin
        if (awready) begin
          beat_next  = '0;
          state_next = DATA;
        end else if (timed_out) begin
          error_type_next = 3'd4;
          state_next      = ERROR;
        end else begin
          stall_next = stall_reg + 32'd1;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (wlast) begin
            offset_next = offset_reg + {23'd0, burst_reg};
            state_next  = RESP;
          end else begin
            beat_next = beat_reg + 9'd1;
          end
        end else if (timed_out) begin
          error_type_next = 3'd6;
          state_next      = ERROR;
        end else begin
          stall_next = stall_reg + 32'd1;
        end
      end
      RESP: begin
        if (bvalid) begin
          if (bresp[1]) begin
            error_type_next = 3'd5;
            state_next      = ERROR;
          end else if (offset_reg >= length_reg) begin
            state_next = DONE;
          end else begin
            state_next = CALC;
          end
        end else if (timed_out) begin
          error_type_next = 3'd7;
          state_next      = ERROR;
        end else begin
          stall_next = stall_reg + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_reg      <= IDLE;
      router_reg     <= '0;
      address_reg    <= '0;
      length_reg     <= '0;
      offset_reg     <= '0;
      burst_reg      <= '0;
      beat_reg       <= '0;
      stall_reg      <= '0;
      error_type_reg <= '0;
      awaddr_reg     <= '0;
      awlen_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      router_reg     <= router_next;
      address_reg    <= address_next;
      length_reg     <= length_next;
      offset_reg     <= offset_next;
      burst_reg      <= burst_next;
      beat_reg       <= beat_next;
      stall_reg      <= stall_next;
      error_type_reg <= error_type_next;
      awaddr_reg     <= awaddr_next;
      awlen_reg      <= awlen_next;
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_burst_writer.sv
// Directed testbench for painterengine_gpu_dma_burst_writer (defaults:
// 4 channels, 32-bit data, 256-beat bursts, 256-cycle timeout).
module tb_painterengine_gpu_dma_burst_writer;
  localparam int C  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [C-1:0]    router = '0;
  logic [32*C-1:0] address = '0, length = '0;
  logic [DW*C-1:0] data;
  logic [C-1:0]    data_valid;
  logic [C-1:0]    data_next;
  logic            busy, done, error;
  logic [2:0]      error_type;
  logic            awid, awlock, awvalid, awready;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize, awprot;
  logic [1:0]      awburst;
  logic [3:0]      awcache, awqos;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic            bid, bvalid, bready;
  logic [1:0]      bresp;

  painterengine_gpu_dma_burst_writer dut (
    .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start),
    .i_wire_router(router), .i_wire_address(address), .i_wire_length(length),
    .i_wire_data(data), .i_wire_data_valid(data_valid), .o_wire_data_next(data_next),
    .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(error_type),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int passed = 0;

  // Slave / source configuration
  bit         aw_en = 1'b1;
  bit         rand_mode = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  int         active_ch = 0;

  // Observation state
  int          b_pending, aw_count, aw_valid_cycles, w_count, data_err, next_err;
  int          wlast_count, wlast_err, wvalid_bad, burst_idx, beat_in_burst;
  int          beat_cnt[C];
  int          exp_idx[C];
  int          next_count[C];
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];

  task automatic clear_model();
    b_pending = 0; aw_count = 0; aw_valid_cycles = 0; w_count = 0; data_err = 0;
    next_err = 0; wlast_count = 0; wlast_err = 0; wvalid_bad = 0;
    burst_idx = 0; beat_in_burst = 0;
    for (int c = 0; c < C; c++) begin
      beat_cnt[c] = 0; exp_idx[c] = 0; next_count[c] = 0;
    end
    aw_addr_q.delete();
    aw_len_q.delete();
  endtask

  // AXI slave and channel sources: drive on the falling edge, observe 1 ns later.
  initial begin : slave_proc
    logic         hs, exp_last;
    logic [C-1:0] exp_next;
    logic [DW-1:0] exp_data;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 1'b0;
    data_valid = '0; data = '0;
    forever begin
      @(negedge clk);
      awready = aw_en;
      wready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < C; c++) begin
        data_valid[c]      = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        data[c*DW +: DW]   = {8'(c + 1), 24'(beat_cnt[c])};
      end
      bvalid = (b_pending > 0);
      bresp  = bresp_cfg;
      #1;
      if (!rst) begin
        if (awvalid) aw_valid_cycles++;
        if (awvalid && awready) begin
          aw_count++;
          aw_addr_q.push_back(awaddr);
          aw_len_q.push_back(awlen);
        end
        if (wvalid && (!busy || awvalid || bready)) wvalid_bad++;
        hs = wvalid && wready;
        exp_next = hs ? C'(1 << active_ch) : '0;
        if (data_next !== exp_next) next_err++;
        for (int c = 0; c < C; c++)
          if (data_next[c]) begin
            next_count[c]++;
            beat_cnt[c]++;
          end
        if (hs) begin
          exp_data = {8'(active_ch + 1), 24'(exp_idx[active_ch])};
          if (wdata !== exp_data) data_err++;
          exp_idx[active_ch]++;
          w_count++;
          exp_last = (burst_idx < aw_len_q.size()) && (beat_in_burst == int'(aw_len_q[burst_idx]));
          if (wlast !== exp_last) wlast_err++;
          if (wlast) begin
            wlast_count++;
            b_pending++;
          end
          if (exp_last) begin
            burst_idx++;
            beat_in_burst = 0;
          end else begin
            beat_in_burst++;
          end
        end
        if (bvalid && bready) b_pending--;
      end
    end
  end

  // Channel ch gets addr/len; every other channel gets a misaligned address so
  // that latching the wrong slice shows up as an error.
  task automatic do_start(input logic [C-1:0] rt, input int ch, input logic [31:0] addr,
                          input logic [31:0] len);
    @(negedge clk);
    clear_model();
    active_ch = ch;
    for (int c = 0; c < C; c++) begin
      address[c*32 +: 32] = (c == ch) ? addr : 32'hDEAD_0003;
      length[c*32 +: 32]  = (c == ch) ? len : 32'd5;
    end
    router = rt;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_end(input int max_cycles, input string name);
    bit ended = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #2;
      if (done || error) begin
        ended = 1'b1;
        break;
      end
    end
    checks++;
    if (!ended) $display("FAIL %s_end: done/error not seen within %0d cycles", name, max_cycles);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_status: got %b want 000", {busy, done, error}); else passed++;
    checks++; if (error_type !== 3'd0) $display("FAIL reset_error_type: got %0d want 0", error_type); else passed++;
    checks++; if ({awvalid, wvalid, wlast, bready} !== 4'b0000) $display("FAIL reset_valids: got %b want 0000", {awvalid, wvalid, wlast, bready}); else passed++;
    checks++; if (data_next !== 4'b0000) $display("FAIL reset_data_next: got %b want 0000", data_next); else passed++;
    checks++; if ({awaddr, awlen} !== 40'd0) $display("FAIL reset_aw: got %h/%h want 0/0", awaddr, awlen); else passed++;
    checks++; if ({awid, awsize, awburst, awlock, awcache, awprot, awqos} !== {1'b0, 3'd2, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0})
      $display("FAIL aw_constants: got id%0d size%0d burst%0d lock%0d cache%0d prot%0d qos%0d", awid, awsize, awburst, awlock, awcache, awprot, awqos);
    else passed++;
    checks++; if (wstrb !== 4'hF) $display("FAIL wstrb: got %h want f", wstrb); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_long_transfer();
    do_start(4'b0010, 1, 32'h1000, 32'd300);
    wait_end(2000, "long");
    checks++; if ({done, error} !== 2'b10) $display("FAIL long_done: got done=%b error=%b want 1/0", done, error); else passed++;
    checks++; if (aw_count !== 2) $display("FAIL long_bursts: got %0d want 2", aw_count); else passed++;
    if (aw_count == 2) begin
      checks++; if (aw_len_q[0] !== 8'd255 || aw_len_q[1] !== 8'd43) $display("FAIL long_awlen: got %0d,%0d want 255,43", aw_len_q[0], aw_len_q[1]); else passed++;
      checks++; if (aw_addr_q[0] !== 32'h1000 || aw_addr_q[1] !== 32'h1400) $display("FAIL long_awaddr: got %h,%h want 1000,1400", aw_addr_q[0], aw_addr_q[1]); else passed++;
    end
    checks++; if (next_count[1] !== 300) $display("FAIL long_next1: got %0d want 300", next_count[1]); else passed++;
    checks++; if (next_count[0] + next_count[2] + next_count[3] !== 0) $display("FAIL long_next_other: got %0d want 0", next_count[0] + next_count[2] + next_count[3]); else passed++;
    checks++; if (data_err !== 0 || next_err !== 0) $display("FAIL long_data: data_err=%0d next_err=%0d want 0/0", data_err, next_err); else passed++;
    checks++; if (wlast_count !== 2 || wlast_err !== 0) $display("FAIL long_wlast: count=%0d err=%0d want 2/0", wlast_count, wlast_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL long_busy: got %b want 0", busy); else passed++;
    $display("long transfer: %0d bursts, %0d beats", aw_count, w_count);
  endtask

  // Started straight from DONE: also exercises back-to-back transfers.
  task automatic test_4k_boundary();
    do_start(4'b0001, 0, 32'h0FF8, 32'd8);
    wait_end(200, "page");
    checks++; if (done !== 1'b1) $display("FAIL page_done: got %b want 1", done); else passed++;
    checks++; if (aw_count !== 2) $display("FAIL page_bursts: got %0d want 2", aw_count); else passed++;
    if (aw_count == 2) begin
      checks++; if (aw_addr_q[0] !== 32'h0FF8 || aw_len_q[0] !== 8'd1) $display("FAIL page_first: got %h len %0d want 0ff8 len 1", aw_addr_q[0], aw_len_q[0]); else passed++;
      checks++; if (aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd5) $display("FAIL page_second: got %h len %0d want 1000 len 5", aw_addr_q[1], aw_len_q[1]); else passed++;
    end
    checks++; if (w_count !== 8 || data_err !== 0) $display("FAIL page_beats: got %0d (err %0d) want 8 (0)", w_count, data_err); else passed++;
    $display("4k boundary: %0d bursts", aw_count);
  endtask

  task automatic test_config_errors();
    logic [C-1:0] rts[3]   = '{4'b0011, 4'b0100, 4'b1000};
    logic [31:0]  addrs[3] = '{32'h1000, 32'h1002, 32'h1000};
    logic [31:0]  lens[3]  = '{32'd4, 32'd4, 32'd0};
    for (int k = 0; k < 3; k++) begin
      do_start(rts[k], (k == 0) ? 0 : k + 1, addrs[k], lens[k]);
      wait_end(20, "cfg");
      checks++; if (error !== 1'b1 || error_type !== 3'(k + 1)) $display("FAIL cfg_error%0d: got error=%b type=%0d want 1/%0d", k, error, error_type, k + 1); else passed++;
      checks++; if (aw_valid_cycles !== 0) $display("FAIL cfg_awvalid%0d: got %0d cycles want 0", k, aw_valid_cycles); else passed++;
      $display("config error case %0d: type %0d", k, error_type);
    end
  endtask

  task automatic test_bresp_error();
    bresp_cfg = 2'b10;
    do_start(4'b0100, 2, 32'h2000, 32'd4);
    wait_end(100, "bresp");
    checks++; if (error !== 1'b1 || error_type !== 3'd5) $display("FAIL bresp_error: got error=%b type=%0d want 1/5", error, error_type); else passed++;
    checks++; if (aw_count !== 1) $display("FAIL bresp_bursts: got %0d want 1", aw_count); else passed++;
    bresp_cfg = 2'b00;
    $display("bresp error: type %0d", error_type);
  endtask

  task automatic test_aw_timeout();
    aw_en = 1'b0;
    do_start(4'b0001, 0, 32'h0, 32'd4);
    repeat (250) @(posedge clk);
    #2;
    checks++; if ({busy, error} !== 2'b10) $display("FAIL awto_early: got busy=%b error=%b want 1/0", busy, error); else passed++;
    wait_end(40, "awto");
    checks++; if (error !== 1'b1 || error_type !== 3'd4) $display("FAIL awto_error: got error=%b type=%0d want 1/4", error, error_type); else passed++;
    aw_en = 1'b1;
    $display("aw timeout: type %0d", error_type);
  endtask

  task automatic test_random_flow();
    rand_mode = 1'b1;
    do_start(4'b1000, 3, 32'h3F00, 32'd600);
    wait_end(8000, "rand");
    rand_mode = 1'b0;
    checks++; if (done !== 1'b1) $display("FAIL rand_done: got %b want 1 (error type %0d)", done, error_type); else passed++;
    checks++; if (w_count !== 600 || data_err !== 0 || next_err !== 0) $display("FAIL rand_data: beats=%0d data_err=%0d next_err=%0d want 600/0/0", w_count, data_err, next_err); else passed++;
    checks++; if (wlast_count !== 4 || wlast_err !== 0) $display("FAIL rand_wlast: count=%0d err=%0d want 4/0", wlast_count, wlast_err); else passed++;
    checks++; if (wvalid_bad !== 0) $display("FAIL rand_wvalid: got %0d stray cycles want 0", wvalid_bad); else passed++;
    if (aw_count == 4) begin
      checks++; if ({aw_len_q[0], aw_len_q[1], aw_len_q[2], aw_len_q[3]} !== {8'd63, 8'd255, 8'd255, 8'd23})
        $display("FAIL rand_awlen: got %0d,%0d,%0d,%0d want 63,255,255,23", aw_len_q[0], aw_len_q[1], aw_len_q[2], aw_len_q[3]);
      else passed++;
      checks++; if (aw_addr_q[1] !== 32'h4000) $display("FAIL rand_awaddr: got %h want 4000", aw_addr_q[1]); else passed++;
    end else begin
      checks++; $display("FAIL rand_bursts: got %0d want 4", aw_count);
    end
    $display("random flow: %0d beats in %0d bursts", w_count, aw_count);
  endtask

  task automatic test_reset_mid_data();
    bit reached = 1'b0;
    do_start(4'b0001, 0, 32'h0, 32'd100);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (w_count >= 10) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached) $display("FAIL rst_mid_reach: beats=%0d want >=10", w_count); else passed++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({busy, awvalid, wvalid, wlast, bready} !== 5'b00000) $display("FAIL rst_mid_outputs: got %b want 00000", {busy, awvalid, wvalid, wlast, bready}); else passed++;
    checks++; if (data_next !== 4'b0000) $display("FAIL rst_mid_next: got %b want 0000", data_next); else passed++;
    @(negedge clk);
    rst = 1'b0;
    do_start(4'b0010, 1, 32'h0100, 32'd16);
    wait_end(200, "rst_mid");
    checks++; if (done !== 1'b1) $display("FAIL rst_mid_done: got %b want 1", done); else passed++;
    checks++; if (w_count !== 16 || next_count[1] !== 16 || data_err !== 0) $display("FAIL rst_mid_beats: got %0d/%0d err %0d want 16/16/0", w_count, next_count[1], data_err); else passed++;
    checks++; if (aw_count !== 1 || aw_len_q[0] !== 8'd15) $display("FAIL rst_mid_aw: got %0d bursts want 1 of len 15", aw_count); else passed++;
    $display("reset mid data: restart moved %0d beats", w_count);
  endtask

  initial begin
    clear_model();
    test_reset();
    test_long_transfer();
    test_4k_boundary();
    test_config_errors();
    test_bresp_error();
    test_aw_timeout();
    test_random_flow();
    test_reset_mid_data();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_dma_burst_writer.md
PAINTERENGINE_GPU_DMA_BURST_WRITER -- requirements
Module: painterengine_gpu_dma_burst_writer

Interface
REQ-001 SHALL have parameter PARAM_CHANNELS, default 4: number of routable source channels (1..8).
REQ-002 SHALL have parameter PARAM_DATA_WIDTH, default 32: AXI data and per-channel beat width in bits (32, 64 or 128).
REQ-003 SHALL have parameter PARAM_MAX_BURST, default 256: maximum AXI beats per burst (power of two, 1..256).
REQ-004 SHALL have parameter PARAM_TIMEOUT, default 256: idle cycles tolerated per handshake before error.
REQ-005 SHALL have one clock and an asynchronous active-high reset; nothing else is fixed beyond the ports listed here.
REQ-006 SHALL have ports: i_wire_clock in 1 clock; i_wire_reset in 1 async active-high reset.
REQ-007 SHALL have ports: i_wire_start in 1 start pulse; i_wire_router in PARAM_CHANNELS one-hot channel select.
REQ-008 SHALL have ports: i_wire_address in 32*PARAM_CHANNELS per-channel byte address; i_wire_length in 32*PARAM_CHANNELS per-channel length in beats.
REQ-009 SHALL have ports: i_wire_data in PARAM_DATA_WIDTH*PARAM_CHANNELS; i_wire_data_valid in PARAM_CHANNELS; o_wire_data_next out PARAM_CHANNELS, a beat-consumed strobe.
REQ-010 SHALL have ports: o_wire_busy out 1; o_wire_done out 1; o_wire_error out 1; o_wire_error_type out 3.
REQ-011 SHALL have AXI4 master write ports: AW (ID 1, ADDR 32, LEN 8, SIZE 3, BURST 2, LOCK, CACHE 4, PROT 3, QOS 4, VALID out; READY in); W (DATA PARAM_DATA_WIDTH, STRB PARAM_DATA_WIDTH/8, LAST, VALID out; READY in); B (ID 1, RESP 2, VALID in; READY out).

Function
REQ-012 SHALL drive constants AWID=0, AWBURST=INCR, AWSIZE=log2(PARAM_DATA_WIDTH/8), AWLOCK=0, AWCACHE=4'b0010, AWPROT=0, AWQOS=0, WSTRB all ones.
REQ-013 SHALL implement states IDLE, CHECK, CALC, ADDR, DATA, RESP, DONE, ERROR.
REQ-014 SHALL, in IDLE, DONE or ERROR, on i_wire_start latch router, address and length, clear the beat offset, and go to CHECK; start in any other state is ignored.
REQ-015 SHALL, in CHECK: router not one-hot or selecting a channel >= PARAM_CHANNELS -> ERROR type 1; address not aligned to PARAM_DATA_WIDTH/8 -> type 2; length 0 -> type 3; otherwise -> CALC.
REQ-016 SHALL, in CALC, set burst = min(PARAM_MAX_BURST, remaining beats, beats left to the next 4 KB boundary); bursts never cross 4 KB.
REQ-017 SHALL hold AWVALID in ADDR with AWADDR = base + offset*bytes and AWLEN = burst-1, both stable until AWREADY; on handshake -> DATA with the beat counter cleared.
REQ-018 SHALL assert WVALID only in DATA and only when the selected channel's data_valid is high; WDATA = the selected channel slice.
REQ-019 SHALL pulse o_wire_data_next only on the selected channel, in the same cycle as WVALID&&WREADY; other bits stay 0.
REQ-020 SHALL assert WLAST combinationally when beat counter == burst-1; after the last beat handshake, add burst to offset and go to RESP.
REQ-021 SHALL assert BREADY in RESP; on BVALID with BRESP OKAY/EXOKAY, go to DONE if offset >= length, else to CALC; on SLVERR/DECERR go to ERROR type 5.
REQ-022 SHALL count consecutive stalled cycles (ADDR without AWREADY, DATA without a handshake, RESP without BVALID), clear the count on any handshake, and at PARAM_TIMEOUT go to ERROR with type 4, 6 or 7 respectively.
REQ-023 SHALL hold o_wire_done high only in DONE and o_wire_error high only in ERROR, with o_wire_error_type stable until the next start; type is 0 when no error.
REQ-024 SHALL hold o_wire_busy high in every state except IDLE, DONE and ERROR.
REQ-025 SHALL allow lengths up to 2^32-1 beats; offset and remaining arithmetic SHALL be 32 bit with no wrap for legal lengths.

Reset
REQ-026 SHALL, while i_wire_reset is high, asynchronously enter IDLE with all valid/ready/last/next/done/error outputs 0, error_type 0 and AWADDR/AWLEN 0; reset mid-burst abandons the transfer without completing WLAST.

Verification
REQ-027 SHALL pass: ch1, addr 0x1000, len 300, MAX_BURST 256, always-ready slave -> bursts of LEN 255 then 43, done, 300 data_next[1] pulses, none on other channels.
REQ-028 SHALL pass: addr 0x0FF8, len 8, 32-bit data -> bursts of 2 beats at 0x0FF8 and 6 beats at 0x1000.
REQ-029 SHALL pass: router 4'b0011 -> error, type 1; addr 0x1002 -> type 2; len 0 -> type 3; no AWVALID in any case.
REQ-030 SHALL pass: BRESP=2'b10 on the first burst -> error type 5; AWREADY held low 256 cycles -> type 4.
REQ-031 SHALL pass: data_valid and WREADY toggled randomly -> data order preserved, WLAST exactly once per burst, WVALID never high outside DATA.
REQ-032 SHALL pass: reset asserted mid-DATA, then a new start -> IDLE immediately, and the next transfer completes correctly.
